// File: rtl/any1_pkg.sv
// Shared ANY-1 reorder-buffer types and constants.
// Consumers: any1_rob_ptr, any1_rob_sched.
package any1_pkg;

    localparam int ROB_ENTRIES = 16;
    localparam int AWID        = 32;
    localparam int EPOCHW      = 6;

    localparam logic [15:0]     FLT_NONE  = 16'h0000;
    localparam logic [15:0]     FLT_UNIMP = 16'h0037;
    localparam logic [AWID-1:0] TRAP_VEC  = 32'hFFFC_0000;

    typedef logic [$clog2(ROB_ENTRIES)-1:0] rid_t;

    // Writeback payload; predict is the fetch-time guess the branch is checked against.
    typedef struct packed {
        logic            rfwr;
        logic [7:0]      Rt;
        logic [63:0]     res;
        logic [15:0]     cause;
        logic            jump;
        logic [AWID-1:0] jump_tgt;
        logic            branch;
        logic            takb;
        logic            predict;
    } sReorderEntry;

endpackage

// File: rtl/any1_rob_ptr.sv
// Head/tail/occupancy tracking for the reorder buffer.
// Pointers wrap modulo ROB_ENTRIES. A flush clears all three.
module any1_rob_ptr import any1_pkg::*; #(
    parameter int  ROB_ENTRIES = any1_pkg::ROB_ENTRIES,
    localparam int RIDW        = $clog2(ROB_ENTRIES)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            push,
    input  logic            pop,
    input  logic            flush,
    output logic [RIDW-1:0] head,
    output logic [RIDW-1:0] tail,
    output logic [RIDW:0]   count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (push)
                tail <= tail + RIDW'(1);
            if (pop)
                head <= head + RIDW'(1);
            case ({push, pop})
                2'b10:   count <= count + (RIDW+1)'(1);
                2'b01:   count <= count - (RIDW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/any1_rob_sched.sv
// In-order commit scheduler for the ANY-1 reorder buffer.
// Define ANY1_ROB_PERF_EN to add saturating retire/full-stall counters.
module any1_rob_sched import any1_pkg::*; #(
    parameter int  ROB_ENTRIES = any1_pkg::ROB_ENTRIES,
    localparam int RIDW        = $clog2(ROB_ENTRIES)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             alloc_v_i,
    input  logic [AWID-1:0]  alloc_ip_i,
    output logic             alloc_rdy_o,
    output logic [RIDW-1:0]  alloc_rid_o,
    output logic [5:0]       epoch_o,
    input  logic             wb_v_i,
    input  logic [RIDW-1:0]  wb_rid_i,
    input  sReorderEntry     wb_i,
    input  logic             cmt_rdy_i,
    output logic             cmt_v_o,
    output logic             cmt_rfwr_o,
    output logic [7:0]       cmt_Rt_o,
    output logic [63:0]      cmt_res_o,
    output logic             flush_o,
    output logic             redir_v_o,
    output logic [AWID-1:0]  redir_ip_o,
    output logic [15:0]      exc_cause_o,
    output logic [AWID-1:0]  exc_ip_o,
    output logic [RIDW:0]    count_o
`ifdef ANY1_ROB_PERF_EN
    ,
    output logic [63:0]      perf_cmt_o,
    output logic [63:0]      perf_full_o
`endif
);

    localparam logic [RIDW:0] FULL_CNT = (RIDW+1)'(ROB_ENTRIES);

    logic [RIDW-1:0]    head, tail;
    logic [RIDW:0]      count;
    logic [ROB_ENTRIES-1:0] v_q, cmt_q;
    logic [AWID-1:0]    ip_q    [ROB_ENTRIES];
    logic [5:0]         epoch_q [ROB_ENTRIES];
    sReorderEntry       pay_q   [ROB_ENTRIES];
    logic [5:0]         epoch;
    logic               flush_q;
    logic [AWID-1:0]    redir_ip_q, exc_ip_q;
    logic [15:0]        exc_cause_q;

    sReorderEntry hd;
    logic hd_live, hd_stale, cand, retire, hd_exc, hd_redir, take_flush;
    logic alloc_fire, wb_fire;

    // Head evaluation; the flush cycle blocks commit so only one retire triggers it.
    assign hd         = pay_q[head];
    assign hd_live    = v_q[head] & ~flush_q;
    assign hd_stale   = hd_live & (epoch_q[head] != epoch);
    assign cand       = hd_live & cmt_q[head] & ~hd_stale;
    assign retire     = cand & cmt_rdy_i;
    assign hd_exc     = hd.cause != FLT_NONE;
    assign hd_redir   = hd.jump | (hd.branch & (hd.takb != hd.predict));
    assign take_flush = retire & (hd_exc | hd_redir);

    assign alloc_rdy_o = (count < FULL_CNT) & ~flush_q;
    assign alloc_fire  = alloc_v_i & alloc_rdy_o;
    assign wb_fire     = wb_v_i & v_q[wb_rid_i] & ~flush_q;

    any1_rob_ptr #(.ROB_ENTRIES(ROB_ENTRIES)) u_ptr (
        .clk   (clk_i),
        .rst   (rst_i),
        .push  (alloc_fire),
        .pop   (retire | hd_stale),
        .flush (flush_q),
        .head  (head),
        .tail  (tail),
        .count (count)
    );

    // Control state: slot flags, epoch and the registered flush/redirect report.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            v_q         <= '0;
            cmt_q       <= '0;
            epoch       <= '0;
            flush_q     <= 1'b0;
            redir_ip_q  <= '0;
            exc_cause_q <= '0;
            exc_ip_q    <= '0;
        end else begin
            flush_q     <= take_flush;
            redir_ip_q  <= take_flush ? (hd_exc ? TRAP_VEC : hd.jump_tgt) : '0;
            exc_cause_q <= (take_flush & hd_exc) ? hd.cause : '0;
            exc_ip_q    <= (take_flush & hd_exc) ? ip_q[head] : '0;
            if (flush_q) begin
                v_q   <= '0;
                epoch <= epoch + 6'd1;
            end else begin
                if (wb_fire)
                    cmt_q[wb_rid_i] <= 1'b1;
                if (retire | hd_stale)
                    v_q[head] <= 1'b0;
                if (alloc_fire) begin
                    v_q[tail]   <= 1'b1;
                    cmt_q[tail] <= 1'b0;
                end
            end
        end
    end

    // Entry payload; only read once the matching valid/cmt flag is set.
    always_ff @(posedge clk_i) begin
        if (alloc_fire) begin
            ip_q[tail]    <= alloc_ip_i;
            epoch_q[tail] <= epoch;
        end
        if (wb_fire)
            pay_q[wb_rid_i] <= wb_i;
    end

    assign alloc_rid_o = tail;
    assign epoch_o     = epoch;
    assign count_o     = count;
    assign cmt_v_o     = cand;
    assign cmt_rfwr_o  = cand & hd.rfwr & ~hd_exc;
    assign cmt_Rt_o    = cand ? hd.Rt  : '0;
    assign cmt_res_o   = cand ? hd.res : '0;
    assign flush_o     = flush_q;
    assign redir_v_o   = flush_q;
    assign redir_ip_o  = redir_ip_q;
    assign exc_cause_o = exc_cause_q;
    assign exc_ip_o    = exc_ip_q;

`ifdef ANY1_ROB_PERF_EN
    function automatic logic [63:0] sat_inc(input logic [63:0] c);
        return (&c) ? c : c + 64'd1;
    endfunction

    logic [63:0] perf_cmt_q, perf_full_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_cmt_q  <= '0;
            perf_full_q <= '0;
        end else begin
            if (retire)
                perf_cmt_q <= sat_inc(perf_cmt_q);
            if (alloc_v_i & (count == FULL_CNT))
                perf_full_q <= sat_inc(perf_full_q);
        end
    end

    assign perf_cmt_o  = perf_cmt_q;
    assign perf_full_o = perf_full_q;
`endif

endmodule

// File: tb/tb_any1_rob_sched.sv
// Directed-vector bench for any1_rob_sched (default 16-entry build).
module tb_any1_rob_sched;
    import any1_pkg::*;

    logic         clk_i, rst_i;
    logic         alloc_v_i;
    logic [31:0]  alloc_ip_i;
    logic         alloc_rdy_o;
    logic [3:0]   alloc_rid_o;
    logic [5:0]   epoch_o;
    logic         wb_v_i;
    logic [3:0]   wb_rid_i;
    sReorderEntry wb;
    logic         cmt_rdy_i;
    logic         cmt_v_o, cmt_rfwr_o;
    logic [7:0]   cmt_Rt_o;
    logic [63:0]  cmt_res_o;
    logic         flush_o, redir_v_o;
    logic [31:0]  redir_ip_o;
    logic [15:0]  exc_cause_o;
    logic [31:0]  exc_ip_o;
    logic [4:0]   count_o;
`ifdef ANY1_ROB_PERF_EN
    logic [63:0]  perf_cmt_o, perf_full_o;
`endif

    int n_cmp = 0;
    int n_err = 0;

    any1_rob_sched dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .alloc_v_i   (alloc_v_i),
        .alloc_ip_i  (alloc_ip_i),
        .alloc_rdy_o (alloc_rdy_o),
        .alloc_rid_o (alloc_rid_o),
        .epoch_o     (epoch_o),
        .wb_v_i      (wb_v_i),
        .wb_rid_i    (wb_rid_i),
        .wb_i        (wb),
        .cmt_rdy_i   (cmt_rdy_i),
        .cmt_v_o     (cmt_v_o),
        .cmt_rfwr_o  (cmt_rfwr_o),
        .cmt_Rt_o    (cmt_Rt_o),
        .cmt_res_o   (cmt_res_o),
        .flush_o     (flush_o),
        .redir_v_o   (redir_v_o),
        .redir_ip_o  (redir_ip_o),
        .exc_cause_o (exc_cause_o),
        .exc_ip_o    (exc_ip_o),
        .count_o     (count_o)
`ifdef ANY1_ROB_PERF_EN
        ,
        .perf_cmt_o  (perf_cmt_o),
        .perf_full_o (perf_full_o)
`endif
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic settle();
        #4;
    endtask

    task automatic set_wb(input logic v, input logic [3:0] rid, input logic [7:0] rt,
                          input logic [63:0] res, input logic [15:0] cause,
                          input logic jump, input logic [31:0] tgt);
        wb_v_i      = v;
        wb_rid_i    = rid;
        wb.rfwr     = 1'b1;
        wb.Rt       = rt;
        wb.res      = res;
        wb.cause    = cause;
        wb.jump     = jump;
        wb.jump_tgt = tgt;
        wb.branch   = 1'b0;
        wb.takb     = 1'b0;
        wb.predict  = 1'b0;
    endtask

    task automatic alloc(input logic v, input logic [31:0] ip);
        alloc_v_i  = v;
        alloc_ip_i = ip;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        alloc(1'b0, 32'h0);
        set_wb(1'b0, 4'd0, 8'd0, 64'd0, FLT_NONE, 1'b0, 32'd0);
        tick();
        rst_i = 1'b0;
    endtask

    initial begin
        rst_i     = 1'b1;
        cmt_rdy_i = 1'b1;
        alloc(1'b0, 32'h0);
        set_wb(1'b0, 4'd0, 8'd0, 64'd0, FLT_NONE, 1'b0, 32'd0);
        #3;
        chk("rst_alloc_rdy", alloc_rdy_o, 1);
        chk("rst_count", count_o, 0);
        chk("rst_cmt_v", cmt_v_o, 0);
        chk("rst_flush", flush_o, 0);
        chk("rst_epoch", epoch_o, 0);
        chk("rst_exc_cause", exc_cause_o, 0);
        tick();
        rst_i = 1'b0;

        // Fill all 16 slots without writeback, then try a 17th.
        for (int i = 0; i < 16; i++) begin
            alloc(1'b1, 32'(i * 4));
            settle();
            chk("fill_rid", alloc_rid_o, i);
            tick();
        end
        settle();
        chk("full_rdy", alloc_rdy_o, 0);
        chk("full_count", count_o, 16);
        chk("full_rid", alloc_rid_o, 0);
        tick();
        settle();
        chk("full_count_hold", count_o, 16);
        chk("full_rid_hold", alloc_rid_o, 0);
        do_reset();

        // Out-of-order writeback, in-order commit.
        for (int i = 0; i < 3; i++) begin
            alloc(1'b1, 32'h40 + 32'(i * 4));
            tick();
        end
        alloc(1'b0, 32'h0);
        set_wb(1'b1, 4'd2, 8'd2, 64'hA, FLT_NONE, 1'b0, 32'd0);
        settle();
        chk("ooo_count", count_o, 3);
        chk("ooo_cmt_v0", cmt_v_o, 0);
        tick();
        set_wb(1'b1, 4'd0, 8'd0, 64'hB, FLT_NONE, 1'b0, 32'd0);
        settle();
        chk("ooo_cmt_v1", cmt_v_o, 0);
        tick();
        set_wb(1'b1, 4'd1, 8'd1, 64'hC, FLT_NONE, 1'b0, 32'd0);
        settle();
        chk("ooo_c0_v", cmt_v_o, 1);
        chk("ooo_c0_res", cmt_res_o, 64'hB);
        chk("ooo_c0_rt", cmt_Rt_o, 0);
        tick();
        wb_v_i = 1'b0;
        settle();
        chk("ooo_c1_v", cmt_v_o, 1);
        chk("ooo_c1_res", cmt_res_o, 64'hC);
        chk("ooo_c1_rt", cmt_Rt_o, 1);
        tick();
        settle();
        chk("ooo_c2_v", cmt_v_o, 1);
        chk("ooo_c2_res", cmt_res_o, 64'hA);
        chk("ooo_c2_rt", cmt_Rt_o, 2);
        tick();
        settle();
        chk("ooo_empty_v", cmt_v_o, 0);
        chk("ooo_empty_cnt", count_o, 0);

        // Backpressure: head stays presented, retires exactly once.
        alloc(1'b1, 32'h80);
        tick();
        alloc(1'b0, 32'h0);
        set_wb(1'b1, 4'd3, 8'd5, 64'h55, FLT_NONE, 1'b0, 32'd0);
        tick();
        wb_v_i    = 1'b0;
        cmt_rdy_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            settle();
            chk("bp_hold_v", cmt_v_o, 1);
            chk("bp_hold_res", cmt_res_o, 64'h55);
            chk("bp_hold_cnt", count_o, 1);
            tick();
        end
        cmt_rdy_i = 1'b1;
        settle();
        chk("bp_go_v", cmt_v_o, 1);
        tick();
        settle();
        chk("bp_once_v", cmt_v_o, 0);
        chk("bp_once_cnt", count_o, 0);

        // Exception at rid1.
        do_reset();
        alloc(1'b1, 32'hFC);  tick();
        alloc(1'b1, 32'h100); tick();
        alloc(1'b1, 32'h104); tick();
        alloc(1'b0, 32'h0);
        set_wb(1'b1, 4'd0, 8'd1, 64'h1, FLT_NONE, 1'b0, 32'd0);
        settle();
        chk("exc_pre_epoch", epoch_o, 0);
        tick();
        set_wb(1'b1, 4'd1, 8'd3, 64'h3, FLT_UNIMP, 1'b0, 32'd0);
        settle();
        chk("exc_c0_v", cmt_v_o, 1);
        chk("exc_c0_rfwr", cmt_rfwr_o, 1);
        tick();
        set_wb(1'b1, 4'd2, 8'd4, 64'h4, FLT_NONE, 1'b0, 32'd0);
        settle();
        chk("exc_c1_v", cmt_v_o, 1);
        chk("exc_c1_rfwr", cmt_rfwr_o, 0);
        chk("exc_c1_rt", cmt_Rt_o, 3);
        chk("exc_c1_noflush", flush_o, 0);
        tick();
        wb_v_i = 1'b0;
        alloc(1'b1, 32'h500);
        settle();
        chk("exc_flush", flush_o, 1);
        chk("exc_redir_v", redir_v_o, 1);
        chk("exc_cause", exc_cause_o, 16'h37);
        chk("exc_ip", exc_ip_o, 32'h100);
        chk("exc_redir_ip", redir_ip_o, TRAP_VEC);
        chk("exc_flush_cmt_v", cmt_v_o, 0);
        chk("exc_flush_rdy", alloc_rdy_o, 0);
        tick();
        alloc(1'b0, 32'h0);
        settle();
        chk("exc_post_flush", flush_o, 0);
        chk("exc_post_epoch", epoch_o, 1);
        chk("exc_post_cnt", count_o, 0);
        chk("exc_post_cause", exc_cause_o, 0);
        chk("exc_post_rid", alloc_rid_o, 0);

        // Jump at head redirects, younger entries and later writebacks die.
        alloc(1'b1, 32'h200); tick();
        alloc(1'b1, 32'h204); tick();
        alloc(1'b1, 32'h208); tick();
        alloc(1'b0, 32'h0);
        set_wb(1'b1, 4'd0, 8'd7, 64'h77, FLT_NONE, 1'b1, 32'hFFFD0040);
        tick();
        wb_v_i = 1'b0;
        settle();
        chk("jmp_cmt_v", cmt_v_o, 1);
        chk("jmp_cmt_rfwr", cmt_rfwr_o, 1);
        chk("jmp_cmt_rt", cmt_Rt_o, 7);
        tick();
        set_wb(1'b1, 4'd1, 8'd8, 64'h88, FLT_NONE, 1'b0, 32'd0);
        settle();
        chk("jmp_flush", flush_o, 1);
        chk("jmp_redir_ip", redir_ip_o, 32'hFFFD0040);
        chk("jmp_exc_cause", exc_cause_o, 0);
        tick();
        set_wb(1'b1, 4'd2, 8'd9, 64'h99, FLT_NONE, 1'b0, 32'd0);
        settle();
        chk("jmp_post_cnt", count_o, 0);
        chk("jmp_post_epoch", epoch_o, 2);
        tick();
        wb_v_i = 1'b0;
        alloc(1'b1, 32'h300);
        settle();
        chk("jmp_stale_v", cmt_v_o, 0);
        tick();
        alloc(1'b0, 32'h0);
        set_wb(1'b1, 4'd0, 8'd2, 64'h99, FLT_NONE, 1'b0, 32'd0);
        settle();
        chk("jmp_new_cnt", count_o, 1);
        chk("jmp_new_notcmt", cmt_v_o, 0);
        tick();
        wb_v_i = 1'b0;
        settle();
        chk("jmp_new_v", cmt_v_o, 1);
        chk("jmp_new_res", cmt_res_o, 64'h99);
        tick();

        // 40 instructions streamed: alloc k, wb k-1, commit k-2 each cycle.
        do_reset();
        for (int k = 0; k < 42; k++) begin
            alloc(k < 40, 32'(k * 4));
            set_wb((k >= 1) && (k <= 40), 4'(k - 1), 8'(k - 1), 64'h1000 + 64'(k - 1),
                   FLT_NONE, 1'b0, 32'd0);
            settle();
            if (k < 40)
                chk("strm_rid", alloc_rid_o, 64'(k % 16));
            if (k >= 2) begin
                chk("strm_cmt_v", cmt_v_o, 1);
                chk("strm_cmt_res", cmt_res_o, 64'h1000 + 64'(k - 2));
            end
            if (k == 20)
                chk("strm_cnt", count_o, 2);
            tick();
        end
        alloc(1'b0, 32'h0);
        wb_v_i = 1'b0;
        settle();
        chk("strm_end_cnt", count_o, 0);
        chk("strm_end_rid", alloc_rid_o, 8);
        tick();

        // Asynchronous reset in the middle of traffic.
        alloc(1'b1, 32'h700); tick();
        alloc(1'b1, 32'h704); tick();
        set_wb(1'b1, 4'd8, 8'd1, 64'h1, FLT_NONE, 1'b0, 32'd0);
        tick();
        settle();
        chk("mid_pre_v", cmt_v_o, 1);
        rst_i = 1'b1;
        #1;
        chk("mid_rst_cnt", count_o, 0);
        chk("mid_rst_rid", alloc_rid_o, 0);
        chk("mid_rst_cmt_v", cmt_v_o, 0);
        chk("mid_rst_rdy", alloc_rdy_o, 1);
        chk("mid_rst_epoch", epoch_o, 0);
        tick();
        rst_i = 1'b0;
        alloc(1'b0, 32'h0);
        wb_v_i = 1'b0;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
